// File: rtl/ioblock_bank_if.sv
// ---------------------------------------------------------------------------
// ioblock_bank_if
//   Fabric-side and configuration-chain signals of one ioblock_bank.
//   Package pads (PIN), the clock and the reset are plain module ports on the bank.
//
//   Qualifier semantics: the chain has no ready. CFG_EN is the only qualifier.
//   One config bit (CFG_DIN) is consumed at every IOCLK rising edge where CFG_EN=1.
//   CFG_CLR and CFG_CAPTURE act on the edge where they are high.
//   CFG_DONE is a one-cycle pulse. CFG_DOUT is valid after every edge.
//
//   master : fabric / configuration controller side
//   slave  : the I/O bank
//
//   Signals
//     TS[NPINS]   fabric output enable (active high)
//     OUT[NPINS]  fabric output data
//     IN[NPINS]   data returned to the fabric
//     CFG_EN      shift-enable for the serial chain
//     CFG_DIN     serial configuration data
//     CFG_CLR     synchronous clear of the shift register and bit counter
//     CFG_CAPTURE copy the active configuration into the shift register
//     CFG_DOUT    serial configuration readback
//     CFG_DONE    pulse: new configuration committed
// ---------------------------------------------------------------------------
interface ioblock_bank_if #(
    parameter int NPINS = 4
);
    logic [NPINS-1:0] TS;
    logic [NPINS-1:0] OUT;
    logic [NPINS-1:0] IN;
    logic             CFG_EN;
    logic             CFG_DIN;
    logic             CFG_CLR;
    logic             CFG_CAPTURE;
    logic             CFG_DOUT;
    logic             CFG_DONE;

    modport master (
        output TS, OUT, CFG_EN, CFG_DIN, CFG_CLR, CFG_CAPTURE,
        input  IN, CFG_DOUT, CFG_DONE
    );

    modport slave (
        input  TS, OUT, CFG_EN, CFG_DIN, CFG_CLR, CFG_CAPTURE,
        output IN, CFG_DOUT, CFG_DONE
    );
endinterface

// File: rtl/ioblock_bank.sv
// ---------------------------------------------------------------------------
// ioblock_bank
//   Bank of NPINS configurable I/O cells between package pads and fabric.
//   Each pin has a tristate-mode mux, optional output/enable registers and an
//   optional registered input path. The configuration is loaded over a
//   bit-serial chain. When the last bit arrives, the new configuration is
//   committed automatically.
//
//   Per-pin config word c = cfg[4i+3:4i]:
//     [1:0] TSMUX  00 = Z, 01 = drive when ts=1, 1x = always drive
//     [2]   DORREG IN from the input register instead of the pad
//     [3]   OREG   drive from registered OUT/TS instead of direct
//
//   Ports
//     IOCLK    in     clock; all flops are rising-edge
//     IORST_N  in     asynchronous active-low reset
//     PIN      inout  package pads [NPINS]
//     io_bus   slave  fabric and config-chain signals (see ioblock_bank_if)
//
//   Optional feature: define IOB_CFG_READBACK_EN to enable CFG_CAPTURE and
//   serial readback on CFG_DOUT. Without that define, CFG_CAPTURE is
//   ignored and CFG_DOUT is tied to 0.
// ---------------------------------------------------------------------------
module ioblock_bank #(
    parameter int NPINS = 4,
    parameter int CFGW  = 4
) (
    input  logic             IOCLK,
    input  logic             IORST_N,
    inout  wire  [NPINS-1:0] PIN,
    ioblock_bank_if.slave    io_bus
);
    localparam int CFG_BITS = NPINS * CFGW;
    localparam int CNTW     = $clog2(CFG_BITS) + 1;
    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(CFG_BITS - 1);

    logic [CFG_BITS-1:0] r_cfg;
    logic [CFG_BITS-1:0] r_shreg;
    logic [CNTW-1:0]     r_bitcnt;
    logic                r_done;
    logic [NPINS-1:0]    r_d_q;
    logic [NPINS-1:0]    r_out_q;
    logic [NPINS-1:0]    r_ts_q;

    logic [CFG_BITS-1:0] w_shift_next;
    logic                w_capture;
    logic [NPINS-1:0]    w_ts;
    logic [NPINS-1:0]    w_od;
    logic [NPINS-1:0]    w_oe;
    logic [NPINS-1:0]    w_in;

    // The incoming bit enters at the MSB. The first bit shifted ends up in
    // cfg bit 0 after CFG_BITS shifts.
    assign w_shift_next = {io_bus.CFG_DIN, r_shreg[CFG_BITS-1:1]};

`ifdef IOB_CFG_READBACK_EN
    assign w_capture       = io_bus.CFG_CAPTURE;
    assign io_bus.CFG_DOUT = r_shreg[0];
`else
    logic w_unused_capture;
    assign w_unused_capture = io_bus.CFG_CAPTURE;
    assign w_capture        = 1'b0;
    assign io_bus.CFG_DOUT  = 1'b0;
`endif

    // Configuration chain. CFG_CLR has priority over capture, and capture has
    // priority over shift. Clearing never touches the active configuration.
    always_ff @(posedge IOCLK or negedge IORST_N) begin
        if (!IORST_N) begin
            r_cfg    <= '0;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (io_bus.CFG_CLR) begin
                r_shreg  <= '0;
                r_bitcnt <= '0;
            end else if (w_capture) begin
                r_shreg  <= r_cfg;
                r_bitcnt <= '0;
            end else if (io_bus.CFG_EN) begin
                r_shreg <= w_shift_next;
                if (r_bitcnt == LAST_BIT) begin
                    // The last bit is taken straight from CFG_DIN, so the
                    // commit happens on the same edge as the final shift.
                    r_cfg    <= w_shift_next;
                    r_bitcnt <= '0;
                    r_done   <= 1'b1;
                end else begin
                    r_bitcnt <= r_bitcnt + 1'b1;
                end
            end
        end
    end

    // Pad-side data registers. They sample every cycle, whatever the mode.
    always_ff @(posedge IOCLK or negedge IORST_N) begin
        if (!IORST_N) begin
            r_d_q   <= '0;
            r_out_q <= '0;
            r_ts_q  <= '0;
        end else begin
            r_d_q   <= PIN;
            r_out_q <= io_bus.OUT;
            r_ts_q  <= io_bus.TS;
        end
    end

    for (genvar g = 0; g < NPINS; g++) begin : g_pin
        logic [CFGW-1:0] w_c;
        assign w_c = r_cfg[g*CFGW +: CFGW];

        assign w_ts[g] = w_c[3] ? r_ts_q[g]  : io_bus.TS[g];
        assign w_od[g] = w_c[3] ? r_out_q[g] : io_bus.OUT[g];
        // TSMUX: 00 -> 0, 01 -> ts, 1x -> 1.
        assign w_oe[g] = (w_c[1:0] == 2'b01) ? w_ts[g] : w_c[1];

        assign PIN[g]  = w_oe[g] ? w_od[g] : 1'bz;
        assign w_in[g] = w_c[2] ? r_d_q[g] : PIN[g];
    end

    assign io_bus.IN       = w_in;
    assign io_bus.CFG_DONE = r_done;
endmodule

// File: tb/tb_ioblock_bank.sv
module tb_ioblock_bank;
    localparam int NP = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT + pads ----------------
    ioblock_bank_if #(.NPINS(NP)) bus ();
    wire  [NP-1:0] pin;
    logic [NP-1:0] ext_en;
    logic [NP-1:0] ext_val;

    for (genvar g = 0; g < NP; g++) begin : g_pad
        assign pin[g] = ext_en[g] ? ext_val[g] : 1'bz;
        pulldown (pin[g]);
    end

    ioblock_bank #(.NPINS(NP), .CFGW(4)) dut (
        .IOCLK   (clk),
        .IORST_N (rst_n),
        .PIN     (pin),
        .io_bus  (bus)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int         sel;   // 0 PIN, 1 IN, 2 CFG_DOUT, 3 CFG_DONE
        logic [3:0] exp;
        string      name;
    } chk_t;

    chk_t        chk_q[$];
    logic [31:0] exp_q[$];   // expected cycle numbers of CFG_DONE pulses
    int checks = 0;
    int errors = 0;

    // Monitor: runs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] obs;
        chk_t       c;
        logic [31:0] want;
        if (bus.CFG_DONE === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d got=1 want=0", cyc);
            end else begin
                want = exp_q.pop_front();
                if (want != 32'(cyc)) begin
                    errors++;
                    $display("FAIL done_cycle got=%0d want=%0d", cyc, want);
                end
            end
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            case (c.sel)
                0:       obs = pin;
                1:       obs = bus.IN;
                2:       obs = {3'b000, bus.CFG_DOUT};
                default: obs = {3'b000, bus.CFG_DONE};
            endcase
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL %s got=%b want=%b (cyc %0d)", c.name, obs, c.exp, cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input int sel, input logic [3:0] v, input string nm);
        chk_t c;
        c.sel  = sel;
        c.exp  = v;
        c.name = nm;
        chk_q.push_back(c);
    endtask

    // Shift bits w[lo..hi], LSB first. If commit is set, the last edge is expected to commit.
    task automatic shift_range(input logic [15:0] w, input int lo, input int hi, input bit commit);
        for (int i = lo; i <= hi; i++) begin
            bus.CFG_EN  = 1'b1;
            bus.CFG_DIN = w[i];
            step();
        end
        bus.CFG_EN  = 1'b0;
        bus.CFG_DIN = 1'b0;
        if (commit) exp_q.push_back(32'(cyc));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] rb;
        logic        rb_bit;
        bus.TS = '0; bus.OUT = '0;
        bus.CFG_EN = 1'b0; bus.CFG_DIN = 1'b0; bus.CFG_CLR = 1'b0; bus.CFG_CAPTURE = 1'b0;
        ext_en = '1; ext_val = '1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;

        // Reset state: bank in Z, IN follows the externally driven pads.
        expect_sig(1, 4'b1111, "rst_in_eq_pin");
        expect_sig(3, 4'b0000, "rst_done");
        expect_sig(2, 4'b0000, "rst_dout");
        step(); step();
        rst_n = 1'b1;
        ext_en = '0;
        bus.OUT = '1; bus.TS = '1;
        expect_sig(0, 4'b0000, "idle_pins_z");
        expect_sig(1, 4'b0000, "idle_in");
        step();

        // Pin 0 TSMUX=01.
        shift_range(16'h0001, 0, 15, 1'b1);
        bus.TS = 4'b0001; bus.OUT = 4'b0001;
        expect_sig(0, 4'b0001, "ts01_drive");
        expect_sig(1, 4'b0001, "ts01_in");
        step();
        bus.TS = 4'b0000; bus.OUT = 4'b1111;
        expect_sig(0, 4'b0000, "ts01_z");
        step();

        // Pin 1 OREG|DORREG|TSMUX=10. Pin 0 stays driving during the shift.
        bus.TS = 4'b1111; bus.OUT = 4'b1101;
        shift_range(16'h00E0, 0, 14, 1'b0);
        expect_sig(0, 4'b0001, "pins_hold_during_shift");
        shift_range(16'h00E0, 15, 15, 1'b1);
        expect_sig(0, 4'b0000, "oreg_pin1_low");
        expect_sig(1, 4'b0000, "oreg_in_low");
        step();
        bus.OUT = 4'b1111;
        expect_sig(0, 4'b0000, "oreg_no_comb_path");
        step();
        expect_sig(0, 4'b0010, "oreg_pin1_high");
        expect_sig(1, 4'b0000, "dorreg_lag");
        step();
        expect_sig(1, 4'b0010, "dorreg_in_high");

        // Partial load, gap, clear (with CFG_EN high, so CLR has priority), then a full load.
        shift_range(16'h01FF, 0, 8, 1'b0);
        for (int i = 0; i < 5; i++) step();
        expect_sig(0, 4'b0010, "gap_cfg_kept");
        bus.CFG_CLR = 1'b1; bus.CFG_EN = 1'b1; bus.CFG_DIN = 1'b1;
        step();
        bus.CFG_CLR = 1'b0; bus.CFG_EN = 1'b0; bus.CFG_DIN = 1'b0;
        expect_sig(0, 4'b0010, "clr_keeps_active");
        shift_range(16'h0003, 0, 14, 1'b0);
        expect_sig(3, 4'b0000, "no_early_commit");
        shift_range(16'h0003, 15, 15, 1'b1);
        expect_sig(0, 4'b0001, "after_clr_load");
        step();

        // Reset in the middle of a load.
        shift_range(16'hFFFF, 0, 9, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_sig(0, 4'b0000, "rst_pins_z");
        expect_sig(1, 4'b0000, "rst_in_zero");
        step(); step();
        rst_n = 1'b1;
        bus.OUT = 4'b1010;
        step();
        shift_range(16'h2222, 0, 15, 1'b1);
        expect_sig(0, 4'b1010, "post_rst_load_pins");
        expect_sig(1, 4'b1010, "post_rst_load_in");
        step();

        // Mixed config, then capture and readback.
        bus.OUT = 4'b1111; bus.TS = 4'b1111;
        rb = 16'hA5C3;
        step();
        shift_range(rb, 0, 15, 1'b1);
        expect_sig(0, 4'b1101, "a5c3_pins");
        step();
        expect_sig(1, 4'b1101, "a5c3_in");
        bus.CFG_CAPTURE = 1'b1;
        step();
        bus.CFG_CAPTURE = 1'b0;
`ifdef IOB_CFG_READBACK_EN
        rb_bit = rb[0];
`else
        rb_bit = 1'b0;
`endif
        expect_sig(2, {3'b000, rb_bit}, "dout_bit0");
        for (int k = 0; k < 15; k++) begin
            shift_range(rb, k, k, 1'b0);
`ifdef IOB_CFG_READBACK_EN
            rb_bit = rb[k+1];
`else
            rb_bit = 1'b0;
`endif
            expect_sig(2, {3'b000, rb_bit}, $sformatf("dout_bit%0d", k + 1));
        end
        shift_range(rb, 15, 15, 1'b1);
        expect_sig(0, 4'b1101, "recommit_same");
        step(); step(); step();

        // Any CFG_DONE pulse that was expected but never seen is an error.
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL done_missing got=%0d pending want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
